// File: rtl/mem_bist_if.sv
// mem_bist_if -- memory-side bus between the BIST engine and the RAM under test.
//
// Parameters:
//   DATA_WIDTH  memory word width in bits
//   ADDR_WIDTH  memory address bus width
//
// Signals:
//   mem_addr    address driven by the BIST engine
//   mem_wdata   write data driven by the BIST engine
//   mem_rdata   read data returned by the memory
//   mem_we      write strobe (one cycle per written word)
//   mem_oe      read strobe
//
// Modports:
//   master      BIST engine side (drives address/data/strobes, receives read data)
//   slave       memory side
interface mem_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_oe,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_oe,
    output mem_rdata
  );

endinterface

// File: rtl/mem_bist.sv
// mem_bist -- two-pass march-style memory built-in self test.
//
// Each run performs two passes. A pass writes every tested word in ascending
// order, then reads every word back in ascending order and compares it with the
// written pattern. Pass 0 writes the inverted index, pass 1 the plain index,
// so every data bit is exercised at both polarities.
//
// Parameters:
//   DATA_WIDTH  memory word width in bits
//   ADDR_WIDTH  memory address bus width
//   MEM_DEPTH   number of words tested (1..2**ADDR_WIDTH)
//   BASE_ADDR   first address tested (addresses wrap modulo 2**ADDR_WIDTH)
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   reset          synchronous, active-low reset
//   start          begin a run (sampled only when not busy)
//   abort          terminate the current run, return to idle
//   mem            memory bus (mem_bist_if master modport)
//   busy           run in progress
//   done           run completed
//   pass           completed run had zero mismatches
//   error_count    saturating mismatch count
//   fail_addr      address of the first mismatch of the run
//   fail_expected  expected data of the first mismatch
//   fail_actual    read data of the first mismatch
//
// Configuration macro:
//   MEM_BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run
//                             (DONE with pass=0, error_count=1). When undefined
//                             the run always covers every index of both passes.
module mem_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  mem_bist_if.master            mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            error_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual
);

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CHECK,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  phase_q, phase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [7:0]            err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;

  logic [DATA_WIDTH-1:0] expected;
  logic                  mismatch;
  logic                  finish;

  // The size cast truncates or zero-extends the index to the word width.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic ph,
                                                    input logic [ADDR_WIDTH-1:0] i);
    logic [DATA_WIDTH-1:0] r;
    r = DATA_WIDTH'(i);
    return ph ? r : ~r;
  endfunction

  always_comb begin
    expected = pattern(phase_q, idx_q);
    mismatch = (state_q == RD_CHECK) && (mem.mem_rdata != expected);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    oe_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    finish      = 1'b0;

    // Abort freezes the error/fail record; an in-flight compare is discarded.
    if (abort && busy_q) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start && !abort) begin
            state_d     = WR;
            idx_d       = '0;
            phase_d     = 1'b0;
            we_d        = 1'b1;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_d       = '0;
            fail_addr_d = '0;
            fail_exp_d  = '0;
            fail_act_d  = '0;
          end
        end

        WR: begin
          if (idx_q == LAST_IDX) begin
            state_d = RD_ISSUE;
            idx_d   = '0;
            oe_d    = 1'b1;
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
            we_d  = 1'b1;
          end
        end

        RD_ISSUE: begin
          state_d = RD_CHECK;
          oe_d    = 1'b1;
        end

        RD_CHECK: begin
          if (mismatch) begin
            err_d = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;
            // The count is cleared at start and never wraps, so zero means
            // this is the first mismatch of the run.
            if (err_q == 8'd0) begin
              fail_addr_d = addr_q;
              fail_exp_d  = expected;
              fail_act_d  = mem.mem_rdata;
            end
          end

          if (STOP_ON_FAIL && mismatch) begin
            finish = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            if (!phase_q) begin
              state_d = WR;
              idx_d   = '0;
              phase_d = 1'b1;
              we_d    = 1'b1;
            end else begin
              finish = 1'b1;
            end
          end else begin
            state_d = RD_ISSUE;
            idx_d   = idx_q + ADDR_WIDTH'(1);
            oe_d    = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (finish) begin
      state_d = DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == 8'd0);
    end

    // Address and data only move when a strobe is issued, so they stay quiet
    // (zero after reset) while the block is idle.
    if (we_d || oe_d) begin
      addr_d  = BASE + idx_d;
      wdata_d = pattern(phase_d, idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_oe    = oe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign error_count   = err_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_exp_q;
  assign fail_actual   = fail_act_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist -- directed self-checking bench for mem_bist.
//
// Instance dut:  MEM_DEPTH=256, BASE_ADDR=0 against a synchronous-read RAM
//                model with selectable read faults.
// Instance dut1: MEM_DEPTH=1, BASE_ADDR=0xFFFF for the single-word boundary.
// Expectations follow MEM_BIST_STOP_ON_FAIL_EN when the build defines it.
module tb_mem_bist;

`ifdef MEM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start1;
  logic abort;

  logic        busy, done, pass;
  logic [7:0]  error_count;
  logic [15:0] fail_addr;
  logic [7:0]  fail_expected, fail_actual;

  logic        busy1, done1, pass1;
  logic [7:0]  error_count1;
  logic [15:0] fail_addr1;
  logic [7:0]  fail_expected1, fail_actual1;

  int vectorCount = 0;
  int missCount   = 0;

  // 0: fault-free, 1: reads of 0x10 return 0x00, 2: every read returns 0xFF
  int faultMode = 0;

  logic [7:0] ram [0:255];
  logic [7:0] ram1;

  int weCount = 0, oeCount = 0, badStrobe = 0;
  int we1Count = 0, oe1Count = 0, bad1Strobe = 0;

  always #5 clk = ~clk;

  mem_bist_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus  ();
  mem_bist_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus1 ();

  mem_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_DEPTH(256), .BASE_ADDR(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .mem           (bus),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .error_count   (error_count),
    .fail_addr     (fail_addr),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

  mem_bist #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MEM_DEPTH(1), .BASE_ADDR(16'hFFFF)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .start         (start1),
    .abort         (abort),
    .mem           (bus1),
    .busy          (busy1),
    .done          (done1),
    .pass          (pass1),
    .error_count   (error_count1),
    .fail_addr     (fail_addr1),
    .fail_expected (fail_expected1),
    .fail_actual   (fail_actual1)
  );

  // Synchronous-read RAM model with read-side fault injection
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_oe) begin
      if (faultMode == 2)
        bus.mem_rdata <= 8'hFF;
      else if (faultMode == 1 && bus.mem_addr == 16'h0010)
        bus.mem_rdata <= 8'h00;
      else
        bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (bus1.mem_we) ram1 <= bus1.mem_wdata;
    if (bus1.mem_oe) bus1.mem_rdata <= ram1;
  end

  // Strobe monitors: count strobes and flag illegal combinations
  always @(negedge clk) begin
    if (bus.mem_we) weCount <= weCount + 1;
    if (bus.mem_oe) oeCount <= oeCount + 1;
    if ((bus.mem_we && bus.mem_oe) || ((bus.mem_we || bus.mem_oe) && !busy))
      badStrobe <= badStrobe + 1;
    if (bus1.mem_we) we1Count <= we1Count + 1;
    if (bus1.mem_oe) oe1Count <= oe1Count + 1;
    if ((bus1.mem_we && bus1.mem_oe) || ((bus1.mem_we || bus1.mem_oe) && !busy1) ||
        ((bus1.mem_we || bus1.mem_oe) && bus1.mem_addr != 16'hFFFF))
      bad1Strobe <= bad1Strobe + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive start/abort for exactly one sampling edge; returns at the negedge
  // of the first cycle after that edge.
  task automatic applyStimulus(input logic s, input logic a);
    @(negedge clk);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic runToDone(output int cycles);
    cycles = 0;
    while (busy && cycles < 5000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles;
    int weBase, oeBase, badBase;

    reset  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    abort  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_done",  done, 0);
    checkOutput("rst_pass",  pass, 0);
    checkOutput("rst_err",   error_count, 0);
    checkOutput("rst_faddr", fail_addr, 0);
    checkOutput("rst_fexp",  fail_expected, 0);
    checkOutput("rst_addr",  bus.mem_addr, 0);
    checkOutput("rst_strb",  {bus.mem_we, bus.mem_oe}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_addr", bus1.mem_addr, 0);

    // Fault-free run
    faultMode = 0;
    weBase = weCount; oeBase = oeCount; badBase = badStrobe;
    applyStimulus(1'b1, 1'b0);
    checkOutput("ok_first_we",    bus.mem_we, 1);
    checkOutput("ok_first_addr",  bus.mem_addr, 16'h0000);
    checkOutput("ok_first_wdata", bus.mem_wdata, 8'hFF);
    checkOutput("ok_busy",        busy, 1);
    runToDone(cycles);
    checkOutput("ok_cycles", cycles, 1536);
    checkOutput("ok_done",   done, 1);
    checkOutput("ok_pass",   pass, 1);
    checkOutput("ok_err",    error_count, 0);
    checkOutput("ok_ram10",  ram[8'h10], 8'h10);
    checkOutput("ok_ramFF",  ram[8'hFF], 8'hFF);
    repeat (3) @(negedge clk);
    checkOutput("ok_done_hold", done, 1);
    checkOutput("ok_we_cnt", weCount - weBase, 512);
    checkOutput("ok_oe_cnt", oeCount - oeBase, 1024);
    checkOutput("ok_bad",    badStrobe - badBase, 0);

    // Read fault at 0x10
    faultMode = 1;
    badBase = badStrobe;
    applyStimulus(1'b1, 1'b0);
    checkOutput("f10_err_clr", error_count, 0);
    checkOutput("f10_done_clr", done, 0);
    runToDone(cycles);
    checkOutput("f10_cycles", cycles, STOP ? 290 : 1536);
    checkOutput("f10_done",   done, 1);
    checkOutput("f10_pass",   pass, 0);
    checkOutput("f10_err",    error_count, STOP ? 1 : 2);
    checkOutput("f10_faddr",  fail_addr, 16'h0010);
    checkOutput("f10_fexp",   fail_expected, 8'hEF);
    checkOutput("f10_fact",   fail_actual, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("f10_bad", badStrobe - badBase, 0);

    // Read data stuck at 0xFF
    faultMode = 2;
    applyStimulus(1'b1, 1'b0);
    runToDone(cycles);
    checkOutput("ff_cycles", cycles, STOP ? 260 : 1536);
    checkOutput("ff_err",    error_count, STOP ? 1 : 255);
    checkOutput("ff_faddr",  fail_addr, 16'h0001);
    checkOutput("ff_fexp",   fail_expected, 8'hFE);
    checkOutput("ff_fact",   fail_actual, 8'hFF);
    checkOutput("ff_pass",   pass, 0);

    // Start while busy is ignored; abort at cycle 700 keeps the fail record
    faultMode = 1;
    applyStimulus(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("sb_addr", bus.mem_addr, 16'h0005);
    checkOutput("sb_we",   bus.mem_we, 1);
    repeat (694) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("ab_busy",  busy, 0);
    checkOutput("ab_done",  done, STOP ? 1 : 0);
    checkOutput("ab_strb",  {bus.mem_we, bus.mem_oe}, 0);
    checkOutput("ab_err",   error_count, 1);
    checkOutput("ab_faddr", fail_addr, 16'h0010);

    // Reset at cycle 300 overrides simultaneous start and abort
    applyStimulus(1'b1, 1'b0);
    repeat (299) @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    checkOutput("mr_busy",  busy, 0);
    checkOutput("mr_done",  done, 0);
    checkOutput("mr_err",   error_count, 0);
    checkOutput("mr_faddr", fail_addr, 0);
    checkOutput("mr_fexp",  fail_expected, 0);
    checkOutput("mr_fact",  fail_actual, 0);
    checkOutput("mr_addr",  bus.mem_addr, 0);
    checkOutput("mr_wdata", bus.mem_wdata, 0);
    checkOutput("mr_strb",  {bus.mem_we, bus.mem_oe}, 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    badBase = badStrobe;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("mr_quiet", badStrobe - badBase, 0);
    checkOutput("mr_idle",  busy, 0);

    // Single-word boundary instance at the top of the address space
    weBase = we1Count; oeBase = oe1Count; badBase = bad1Strobe;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cycles = 0;
    while (busy1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("d1_cycles", cycles, 6);
    checkOutput("d1_done",   done1, 1);
    checkOutput("d1_pass",   pass1, 1);
    checkOutput("d1_err",    error_count1, 0);
    checkOutput("d1_ram",    ram1, 8'h00);
    repeat (2) @(negedge clk);
    checkOutput("d1_we_cnt", we1Count - weBase, 2);
    checkOutput("d1_oe_cnt", oe1Count - oeBase, 4);
    checkOutput("d1_bad",    bad1Strobe - badBase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
